// File: rtl/ring_tdm_mux.sv
// ring_tdm_mux: time-division multiplexer that follows the one-hot phase of a
// ring counter. Each legal phase grants one channel into a single registered
// output stage with a valid/ready handshake. An illegal phase is flagged and
// the block waits for the ring's reset pattern before granting again.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ring[N]               one-hot phase from the ring counter
//   ch_data[N*DW]         channel words, slot s at [s*DW +: DW]
//   ch_valid[N]           per-channel word available
//   ch_ready[N]           per-channel grant (at most one bit high)
//   out_data, out_slot    captured word and the slot it came from
//   out_valid, out_ready  output handshake
//   phase_err             sticky illegal-phase flag
//   err_cnt               illegal phases seen, saturating at 255
//   frame_cnt             completed frames, wrapping
//   miss_cnt[N*8]         per-slot backpressure misses
//
// Optional feature: define RING_TDM_STATS_EN to build the miss counters;
// otherwise miss_cnt is constant zero.
module ring_tdm_mux #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         ring,
  input  logic [N*DW-1:0]      ch_data,
  input  logic [N-1:0]         ch_valid,
  output logic [N-1:0]         ch_ready,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_slot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 phase_err,
  output logic [7:0]           err_cnt,
  output logic [7:0]           frame_cnt,
  output logic [N*8-1:0]       miss_cnt
);

  localparam int SW = $clog2(N);
  localparam logic [N-1:0] SYNC_PAT = {1'b1, {(N-1){1'b0}}};

  typedef enum logic {SYNC, RUN} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  prev_ring;
  logic [N-1:0]  expected;
  logic          legal;
  logic          illegal;
  logic          grant_ok;
  logic          xfer;
  logic [SW-1:0] slot;
  logic [DW-1:0] word;

  always_comb begin
    expected  = {prev_ring[N-2:0], prev_ring[N-1]};
    legal     = (state == RUN) && (ring == expected);
    illegal   = (state == RUN) && (ring != expected);
    grant_ok  = !out_valid || out_ready;
    slot      = '0;
    word      = '0;
    // Only meaningful when legal, where ring is guaranteed one-hot.
    for (int unsigned i = 0; i < N; i++) begin
      if (ring[i]) begin
        slot = i[SW-1:0];
        word = ch_data[i*DW +: DW];
      end
    end
    ch_ready = '0;
    if (legal && grant_ok) ch_ready[slot] = 1'b1;
    xfer = |(ch_ready & ch_valid);
    state_nxt = state;
    case (state)
      SYNC:    if (ring == SYNC_PAT) state_nxt = RUN;
      RUN:     if (illegal) state_nxt = SYNC;
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      prev_ring <= '0;
      out_data  <= '0;
      out_slot  <= '0;
      out_valid <= 1'b0;
      phase_err <= 1'b0;
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN || ring == SYNC_PAT) prev_ring <= ring;

      if (xfer) begin
        out_data  <= word;
        out_slot  <= slot;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (illegal) begin
        phase_err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
      end

      if (legal && ring == SYNC_PAT) frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef RING_TDM_STATS_EN
  logic [7:0] miss_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) miss_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (legal && ring[i] && ch_valid[i] && !ch_ready[i] && miss_q[i] != '1)
          miss_q[i] <= miss_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    miss_cnt = '0;
    for (int unsigned i = 0; i < N; i++) miss_cnt[i*8 +: 8] = miss_q[i];
  end
`else
  always_comb miss_cnt = '0;
`endif

endmodule

// File: doc/ring_tdm_mux.md
# ring_tdm_mux

Time-division multiplexer that sits directly downstream of the 4-bit ring counter and consumes its one-hot `count` as a slot-select phase. Each cycle it grants one of N input channels according to the active ring bit, captures that channel's word into a single registered output stage with valid/ready handshake, and checks that the ring sequence is legal. Illegal phases are flagged and the block resynchronises on the ring's reset pattern.

## Interface
Parameters:
- `N`, 4, number of slots; equals ring counter width.
- `DW`, 8, channel data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `ring`  in  N  one-hot phase from ring counter; reset pattern is bit N-1 (4'b1000); legal sequence is rotate-left each cycle (1000→0001→0010→0100→1000).
- `ch_data`  in  N*DW  channel words; slot s at bits [s*DW +: DW].
- `ch_valid`  in  N  per-channel word available.
- `ch_ready`  out  N  per-channel grant; at most one bit high.
- `out_data`  out  DW  captured word.
- `out_slot`  out  $clog2(N)  slot index of captured word.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts word.
- `phase_err`  out  1  sticky: an illegal ring phase has been seen since reset.
- `err_cnt`  out  8  count of illegal phases, saturates at 255.
- `frame_cnt`  out  8  completed frames, wraps 255→0.
- `miss_cnt`  out  N*8  per-slot miss counters (see Configuration).

## Operation
- FSM states: SYNC, RUN. Reset state SYNC.
- SYNC: all `ch_ready` low. When `ring` == 1<<(N-1), register it as `prev_ring`, go RUN next cycle. Otherwise stay.
- RUN: `expected` = rotate-left(`prev_ring`); `prev_ring` <= `ring` every cycle.
  - `ring` == `expected`: active slot s = index of set bit; `ch_ready[s]` = !out_valid || out_ready; all other bits 0.
  - `ring` != `expected` (zero, multi-hot, or wrong bit): all `ch_ready` low, no capture, `phase_err` <= 1, `err_cnt` += 1 (saturating), next state SYNC.
- Transfer: `ch_valid[s]` && `ch_ready[s]` → `out_data` <= ch_data[s], `out_slot` <= s, `out_valid` <= 1.
- Drain: `out_valid` && `out_ready` with no new transfer → `out_valid` <= 0. Drain and transfer in same cycle → new word replaces old, `out_valid` stays 1.
- `out_valid` && !`out_ready`: output registers hold, all `ch_ready` low.
- `frame_cnt` increments on each legal RUN cycle where `ring` == 1<<(N-1).

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_slot` 0, `ch_ready` 0, `phase_err` 0, `err_cnt` 0, `frame_cnt` 0, `miss_cnt` all 0, `prev_ring` 0, state SYNC.
- `ch_ready` is combinational from `ring`, state, `out_valid`, `out_ready`.
- Capture latency: handshake at edge t → word on `out_data` with `out_valid` high after edge t (visible cycle t+1).
- Sync latency: ring at 1000 in SYNC at cycle t → first grant possible at cycle t+1 on slot 0.
- Reset mid-transfer: `rst` wins over all; a held output word is discarded even if `out_ready` is low.
- Error and frame boundary coincide (illegal phase while expecting 1000): error path only, `frame_cnt` unchanged.

## Configuration
- `RING_TDM_STATS_EN` defined: `miss_cnt[s]` (8 bits, saturating at 255) increments on each legal RUN cycle where slot s is active, `ch_valid[s]` is 1, and `ch_ready[s]` is 0 (backpressure miss).
- Not defined: no counter logic; `miss_cnt` driven constant 0. All other behaviour identical.

## Test plan
- Reset, drive legal ring from 1000, all `ch_valid`=1, `ch_data`={8'h33,8'h22,8'h11,8'h00}, `out_ready`=1 → words 00,11,22,33 with `out_slot` 0,1,2,3 on consecutive cycles; `frame_cnt`=1 after the second 1000.
- Same stimulus, `out_ready`=0 for 3 cycles after first capture → `out_data`=00 held, `ch_ready` all 0; with macro, `miss_cnt` for slots 1,2,3 each = 1.
- In RUN, inject ring=0110 → `ch_ready` 0 that cycle, `phase_err`=1, `err_cnt`=1, state SYNC; no grants until ring=1000 reappears, then slot 0 grant next cycle.
- Inject 256 illegal phases (resyncing between) → `err_cnt` stays 255.
- Assert `rst` with `out_valid`=1, `out_ready`=0 → next cycle `out_valid`=0, all counters 0, state SYNC.
- Drain and new transfer same cycle (`out_ready`=1, `ch_valid[s]`=1) → `out_valid` stays 1, `out_data` updates to new word with no bubble.
